// File: rtl/ysyx_23060203_csr_pkg.sv
// M-mode CSR package: CSR addresses, mstatus bit positions, exception codes.
// Shared by the writeback/CSR stage, its counter sub-block and the bench.
// Pure definitions, no logic.
package ysyx_23060203_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    CAUSE_INSN_MISALIGN  = 4'd0,
    CAUSE_INSN_FAULT     = 4'd1,
    CAUSE_ILLEGAL_INSN   = 4'd2,
    CAUSE_BREAKPOINT     = 4'd3,
    CAUSE_LOAD_MISALIGN  = 4'd4,
    CAUSE_LOAD_FAULT     = 4'd5,
    CAUSE_STORE_MISALIGN = 4'd6,
    CAUSE_STORE_FAULT    = 4'd7,
    CAUSE_ECALL_U        = 4'd8,
    CAUSE_ECALL_S        = 4'd9,
    CAUSE_ECALL_M        = 4'd11
  } exc_cause_e;

endpackage

// File: rtl/ysyx_23060203_wbu_csr_if.sv
// EXU -> WBU retire bundle: one instruction result per valid/ready handshake.
// Latency: wires only.
// Backpressure: the WBU drops in_ready for the cycle that follows a flushing insn.
interface ysyx_23060203_wbu_csr_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      in_gpr_waddr;
  logic [XLEN-1:0] in_gpr_wdata;
  logic            in_csr_wen;
  logic [11:0]     in_csr_waddr;
  logic [XLEN-1:0] in_csr_wdata;
  logic            in_exc;
  logic [3:0]      in_cause;
  logic            in_ret;
  logic            in_fencei;

  modport master (
    output in_valid, in_pc, in_gpr_waddr, in_gpr_wdata, in_csr_wen, in_csr_waddr,
           in_csr_wdata, in_exc, in_cause, in_ret, in_fencei,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_gpr_waddr, in_gpr_wdata, in_csr_wen, in_csr_waddr,
           in_csr_wdata, in_exc, in_cause, in_ret, in_fencei,
    output in_ready
  );
endinterface

// File: rtl/ysyx_23060203_csr_counter.sv
// 64-bit performance counter with independent low/high half write ports.
// Latency: one cycle from inc or write to the new value.
// Backpressure: none; a half write replaces that half and suppresses the increment.
module ysyx_23060203_csr_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  input  logic        wen_lo,
  input  logic        wen_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  // Software writes win over counting; the 64-bit sum wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= 64'd0;
    end else if (wen_lo) begin
      value[31:0] <= wdata;
    end else if (wen_hi) begin
      value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_23060203_wbu_csr.sv
// Writeback/retire stage: commits GPR writes, owns the M-mode CSR file, redirects the CSU.
// Latency: GPR write combinational with accept; CSR update and flush take effect next cycle.
// Backpressure: in_ready is low during the flush cycle, so the wrong-path slot is never taken.
module ysyx_23060203_wbu_csr
  import ysyx_23060203_csr_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_MTVEC  = 32'h3000_0000,
  parameter bit          HAS_COUNTERS = 1'b1,
  parameter logic [31:0] MVENDORID    = 32'h7973_7978,
  parameter logic [31:0] MARCHID      = 32'h015f_deeb
) (
  input  logic                  clock,
  input  logic                  reset,
  ysyx_23060203_wbu_csr_if.slave exu,
  output logic                  gpr_wen,
  output logic [4:0]            gpr_waddr,
  output logic [XLEN-1:0]       gpr_wdata,
  input  logic [11:0]           csr_raddr,
  output logic [XLEN-1:0]       csr_rdata,
  output logic                  cs_flush,
  output logic [XLEN-1:0]       cs_dnpc,
  output logic                  fencei
);

  if (XLEN != 32) begin : g_xlen_check
    $error("ysyx_23060203_wbu_csr supports XLEN == 32 only");
  end

  logic            accept;
  logic            do_trap;
  logic            do_ret;
  logic            do_csr;
  logic            flush_req;
  logic [3:0]      trap_cause;

  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mscratch;
  logic            mie;
  logic            mpie;
  logic            fencei_r;

  logic [63:0]     mcycle_q;
  logic [63:0]     minstret_q;
  logic            wr_mcycle;
  logic            wr_mcycleh;
  logic            wr_minstret;
  logic            wr_minstreth;
  logic [XLEN-1:0] mstatus_rd;

  assign exu.in_ready = ~cs_flush;
  assign accept       = exu.in_valid & exu.in_ready;

  // Exception beats mret beats CSR write; ebreak shows up as exc+ret and traps with cause 3.
  assign do_trap    = accept & exu.in_exc;
  assign do_ret     = accept & ~exu.in_exc & exu.in_ret;
  assign do_csr     = accept & ~exu.in_exc & ~exu.in_ret & exu.in_csr_wen;
  assign trap_cause = exu.in_ret ? CAUSE_BREAKPOINT : exu.in_cause;
  assign flush_req  = accept & (exu.in_csr_wen | exu.in_exc | exu.in_ret | exu.in_fencei);

  assign gpr_wen   = accept & ~exu.in_exc & (exu.in_gpr_waddr != 5'd0);
  assign gpr_waddr = exu.in_gpr_waddr;
  assign gpr_wdata = exu.in_gpr_wdata;

  assign wr_mcycle    = do_csr & (exu.in_csr_waddr == CSR_MCYCLE);
  assign wr_mcycleh   = do_csr & (exu.in_csr_waddr == CSR_MCYCLEH);
  assign wr_minstret  = do_csr & (exu.in_csr_waddr == CSR_MINSTRET);
  assign wr_minstreth = do_csr & (exu.in_csr_waddr == CSR_MINSTRETH);

  // Trap entry, mret and software writes to the architectural CSRs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtvec    <= RESET_MTVEC;
      mepc     <= '0;
      mcause   <= '0;
      mscratch <= '0;
      mie      <= 1'b0;
      mpie     <= 1'b0;
    end else if (do_trap) begin
      mepc   <= exu.in_pc;
      mcause <= {{(XLEN-4){1'b0}}, trap_cause};
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (do_ret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (do_csr) begin
      case (exu.in_csr_waddr)
        CSR_MSTATUS: begin
          mie  <= exu.in_csr_wdata[MSTATUS_MIE];
          mpie <= exu.in_csr_wdata[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec    <= {exu.in_csr_wdata[XLEN-1:2], 2'b00};
        CSR_MEPC:     mepc     <= {exu.in_csr_wdata[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause   <= exu.in_csr_wdata;
        CSR_MSCRATCH: mscratch <= exu.in_csr_wdata;
        default: ;
      endcase
    end
  end

  if (HAS_COUNTERS) begin : g_counters
    ysyx_23060203_csr_counter u_mcycle (
      .clock  (clock),
      .reset  (reset),
      .inc    (1'b1),
      .wen_lo (wr_mcycle),
      .wen_hi (wr_mcycleh),
      .wdata  (exu.in_csr_wdata),
      .value  (mcycle_q)
    );

    ysyx_23060203_csr_counter u_minstret (
      .clock  (clock),
      .reset  (reset),
      .inc    (accept & ~exu.in_exc),
      .wen_lo (wr_minstret),
      .wen_hi (wr_minstreth),
      .wdata  (exu.in_csr_wdata),
      .value  (minstret_q)
    );
  end else begin : g_no_counters
    assign mcycle_q   = 64'd0;
    assign minstret_q = 64'd0;
  end

  // Redirect is registered; the target is captured from the CSR state seen by the retiring insn.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_flush <= 1'b0;
      fencei_r <= 1'b0;
      cs_dnpc  <= '0;
    end else begin
      cs_flush <= flush_req;
      fencei_r <= accept & exu.in_fencei;
      if (flush_req) begin
        cs_dnpc <= exu.in_exc ? mtvec :
                   exu.in_ret ? mepc  :
                   exu.in_pc + XLEN'(4);
      end
    end
  end

  assign fencei = cs_flush & fencei_r;

  // Combinational read port; a same-cycle write is not forwarded (the flush hides it).
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = mie;
    mstatus_rd[MSTATUS_MPIE] = mpie;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    csr_rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MTVEC:     csr_rdata = mtvec;
      CSR_MEPC:      csr_rdata = mepc;
      CSR_MCAUSE:    csr_rdata = mcause;
      CSR_MSCRATCH:  csr_rdata = mscratch;
      CSR_MCYCLE:    csr_rdata = mcycle_q[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
      CSR_MINSTRET:  csr_rdata = minstret_q[31:0];
      CSR_MINSTRETH: csr_rdata = minstret_q[63:32];
      CSR_MVENDORID: csr_rdata = MVENDORID;
      CSR_MARCHID:   csr_rdata = MARCHID;
      default:       csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_wbu_csr.sv
// Bench for the writeback/CSR stage: directed retire sequences with hand-computed results.
// Expectations are queued by the stimulus with the cycle they are due in;
// a negedge monitor pops them whenever the DUT shows a flush, a GPR write or a probe.
module tb_ysyx_23060203_wbu_csr;
  import ysyx_23060203_csr_pkg::*;

  localparam int SEL_RDATA = 0;
  localparam int SEL_READY = 1;
  localparam int SEL_GWEN  = 2;
  localparam int SEL_FLUSH = 3;
  localparam int SEL_FENCE = 4;

  typedef struct { int cyc; logic [31:0] dnpc; logic fi; } flush_t;
  typedef struct { int cyc; logic [4:0] a; logic [31:0] d; } gpr_t;
  typedef struct { int cyc; int sel; logic [31:0] exp; string name; } chk_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        cs_flush;
  logic [31:0] cs_dnpc;
  logic        fencei;

  int cyc   = 0;
  int nvec  = 0;
  int nbad  = 0;
  bit done  = 1'b0;

  flush_t flush_q[$];
  gpr_t   gpr_q[$];
  chk_t   chk_q[$];

  ysyx_23060203_wbu_csr_if #(.XLEN(32)) exu ();

  ysyx_23060203_wbu_csr dut (
    .clock     (clock),
    .reset     (reset),
    .exu       (exu),
    .gpr_wen   (gpr_wen),
    .gpr_waddr (gpr_waddr),
    .gpr_wdata (gpr_wdata),
    .csr_raddr (csr_raddr),
    .csr_rdata (csr_rdata),
    .cs_flush  (cs_flush),
    .cs_dnpc   (cs_dnpc),
    .fencei    (fencei)
  );

  always #5 clock = ~clock;

  // Cycle index used to time-stamp expectations.
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: consume expectations as the DUT produces events; finish the run when told to.
  always @(negedge clock) begin
    flush_t f;
    gpr_t   g;
    chk_t   c;
    logic [31:0] got;
    if (cs_flush) begin
      nvec++;
      if (flush_q.size() == 0) begin
        nbad++;
        $display("FAIL flush_unexpected cyc=%0d dnpc=%h fencei=%b", cyc, cs_dnpc, fencei);
      end else begin
        f = flush_q.pop_front();
        if (f.cyc != cyc || cs_dnpc !== f.dnpc || fencei !== f.fi) begin
          nbad++;
          $display("FAIL flush got cyc=%0d dnpc=%h fencei=%b, want cyc=%0d dnpc=%h fencei=%b",
                   cyc, cs_dnpc, fencei, f.cyc, f.dnpc, f.fi);
        end
      end
    end
    if (gpr_wen) begin
      nvec++;
      if (gpr_q.size() == 0) begin
        nbad++;
        $display("FAIL gpr_unexpected cyc=%0d x%0d=%h", cyc, gpr_waddr, gpr_wdata);
      end else begin
        g = gpr_q.pop_front();
        if (g.cyc != cyc || gpr_waddr !== g.a || gpr_wdata !== g.d) begin
          nbad++;
          $display("FAIL gpr got cyc=%0d x%0d=%h, want cyc=%0d x%0d=%h",
                   cyc, gpr_waddr, gpr_wdata, g.cyc, g.a, g.d);
        end
      end
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      c = chk_q.pop_front();
      case (c.sel)
        SEL_RDATA: got = csr_rdata;
        SEL_READY: got = {31'd0, exu.in_ready};
        SEL_GWEN:  got = {31'd0, gpr_wen};
        SEL_FLUSH: got = {31'd0, cs_flush};
        default:   got = {31'd0, fencei};
      endcase
      nvec++;
      if (got !== c.exp || c.cyc != cyc) begin
        nbad++;
        $display("FAIL %s got %h (cyc %0d), want %h (cyc %0d)", c.name, got, cyc, c.exp, c.cyc);
      end
    end
    if (done) begin
      nvec++;
      if (flush_q.size() != 0) begin
        nbad++;
        $display("FAIL flush_missing got %0d left, want 0", flush_q.size());
      end
      nvec++;
      if (gpr_q.size() != 0) begin
        nbad++;
        $display("FAIL gpr_missing got %0d left, want 0", gpr_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got no end of test, want finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    exu.in_valid     = 1'b0;
    exu.in_pc        = 32'd0;
    exu.in_gpr_waddr = 5'd0;
    exu.in_gpr_wdata = 32'd0;
    exu.in_csr_wen   = 1'b0;
    exu.in_csr_waddr = 12'd0;
    exu.in_csr_wdata = 32'd0;
    exu.in_exc       = 1'b0;
    exu.in_cause     = 4'd0;
    exu.in_ret       = 1'b0;
    exu.in_fencei    = 1'b0;
  endtask

  task automatic begin_insn(input logic [31:0] pc);
    idle();
    exu.in_valid = 1'b1;
    exu.in_pc    = pc;
  endtask

  task automatic csr_insn(input logic [31:0] pc, input logic [11:0] a, input logic [31:0] d);
    begin_insn(pc);
    exu.in_csr_wen   = 1'b1;
    exu.in_csr_waddr = a;
    exu.in_csr_wdata = d;
  endtask

  task automatic exp_flush(input logic [31:0] dnpc, input logic fi);
    flush_q.push_back('{cyc + 1, dnpc, fi});
  endtask

  task automatic exp_gpr(input logic [4:0] a, input logic [31:0] d);
    gpr_q.push_back('{cyc, a, d});
  endtask

  task automatic exp_sig(input int sel, input logic [31:0] v, input string name);
    chk_q.push_back('{cyc, sel, v, name});
  endtask

  task automatic exp_rd(input logic [11:0] a, input logic [31:0] v, input string name);
    csr_raddr = a;
    chk_q.push_back('{cyc, SEL_RDATA, v, name});
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] v, input string name);
    exp_rd(a, v, name);
    step();
  endtask

  // Accept cycle, then the flush cycle with nothing offered.
  task automatic fire();
    step();
    idle();
    step();
  endtask

  initial begin
    idle();
    csr_raddr = 12'd0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    exp_sig(SEL_FLUSH, 32'd0, "rst_flush");
    exp_sig(SEL_READY, 32'd1, "rst_ready");
    rd(CSR_MTVEC,     32'h3000_0000, "rst_mtvec");
    rd(CSR_MSTATUS,   32'h0000_1800, "rst_mstatus");
    rd(CSR_MEPC,      32'h0,         "rst_mepc");
    rd(CSR_MCAUSE,    32'h0,         "rst_mcause");
    rd(CSR_MVENDORID, 32'h7973_7978, "mvendorid");
    rd(CSR_MARCHID,   32'h015f_deeb, "marchid");
    rd(12'h7C0,       32'h0,         "unknown_csr");
    rd(CSR_MINSTRET,  32'h0,         "rst_minstret");

    // mtvec write with a GPR write; old value visible during the write
    csr_insn(32'h100, CSR_MTVEC, 32'h8000_0103);
    exu.in_gpr_waddr = 5'd1;
    exu.in_gpr_wdata = 32'h55;
    exp_gpr(5'd1, 32'h55);
    exp_flush(32'h104, 1'b0);
    exp_rd(CSR_MTVEC, 32'h3000_0000, "mtvec_old_during_write");
    fire();
    rd(CSR_MTVEC, 32'h8000_0100, "mtvec_aligned");

    // Enable MIE
    csr_insn(32'h180, CSR_MSTATUS, 32'h0000_0008);
    exp_flush(32'h184, 1'b0);
    fire();
    rd(CSR_MSTATUS, 32'h0000_1808, "mstatus_mie_set");

    // ecall: GPR write suppressed, trap state captured, redirect to mtvec
    begin_insn(32'h200);
    exu.in_exc       = 1'b1;
    exu.in_cause     = 4'd11;
    exu.in_gpr_waddr = 5'd3;
    exu.in_gpr_wdata = 32'h33;
    exp_flush(32'h8000_0100, 1'b0);
    exp_sig(SEL_GWEN, 32'd0, "exc_gpr_suppressed");
    fire();
    rd(CSR_MEPC,     32'h0000_0200, "trap_mepc");
    rd(CSR_MCAUSE,   32'h0000_000B, "trap_mcause");
    rd(CSR_MSTATUS,  32'h0000_1880, "trap_mstatus");
    rd(CSR_MINSTRET, 32'h2,         "minstret_after_exc");

    // mret, with a wrong-path insn offered in the flush cycle
    begin_insn(32'h8000_0100);
    exu.in_ret = 1'b1;
    exp_flush(32'h200, 1'b0);
    step();
    begin_insn(32'h8000_0104);
    exu.in_gpr_waddr = 5'd5;
    exu.in_gpr_wdata = 32'h77;
    exp_sig(SEL_READY, 32'd0, "flush_cycle_not_ready");
    exp_sig(SEL_GWEN,  32'd0, "flush_cycle_no_gpr");
    step();
    idle();
    exp_sig(SEL_READY, 32'd1, "ready_after_flush");
    rd(CSR_MSTATUS,  32'h0000_1888, "mret_mstatus");
    rd(CSR_MINSTRET, 32'h3,         "minstret_after_mret");

    // Counter writes: low half carries into high half on the next increment
    csr_insn(32'h400, CSR_MCYCLEH, 32'h0);
    exp_flush(32'h404, 1'b0);
    fire();
    csr_insn(32'h404, CSR_MCYCLE, 32'hFFFF_FFFF);
    exp_flush(32'h408, 1'b0);
    step();
    idle();
    exp_rd(CSR_MCYCLE, 32'hFFFF_FFFF, "mcycle_written");
    step();
    rd(CSR_MCYCLEH,  32'h1, "mcycleh_carry");
    rd(CSR_MINSTRET, 32'h5, "minstret_count");
    csr_insn(32'h408, CSR_MINSTRETH, 32'h5);
    exp_flush(32'h40C, 1'b0);
    fire();
    rd(CSR_MINSTRETH, 32'h5, "minstreth_written");
    rd(CSR_MINSTRET,  32'h5, "minstret_write_overrides_inc");

    // x0 write dropped; plain GPR write does not flush
    begin_insn(32'h500);
    exu.in_gpr_wdata = 32'h99;
    exp_sig(SEL_GWEN, 32'd0, "x0_no_wen");
    step();
    idle();
    exp_sig(SEL_FLUSH, 32'd0, "x0_no_flush");
    step();
    begin_insn(32'h504);
    exu.in_gpr_waddr = 5'd7;
    exu.in_gpr_wdata = 32'h1234;
    exp_gpr(5'd7, 32'h1234);
    step();
    idle();
    exp_sig(SEL_FLUSH, 32'd0, "gpr_no_flush");
    step();

    // fence.i
    begin_insn(32'h300);
    exu.in_fencei = 1'b1;
    exp_flush(32'h304, 1'b1);
    fire();
    exp_sig(SEL_FENCE, 32'd0, "fencei_one_cycle");
    step();

    // Masking and read-only behaviour
    csr_insn(32'h600, CSR_MSCRATCH, 32'hDEAD_BEEF);
    exp_flush(32'h604, 1'b0);
    fire();
    rd(CSR_MSCRATCH, 32'hDEAD_BEEF, "mscratch");
    csr_insn(32'h604, CSR_MEPC, 32'h0000_1237);
    exp_flush(32'h608, 1'b0);
    fire();
    rd(CSR_MEPC, 32'h0000_1234, "mepc_aligned");
    csr_insn(32'h608, CSR_MVENDORID, 32'h0);
    exp_flush(32'h60C, 1'b0);
    fire();
    rd(CSR_MVENDORID, 32'h7973_7978, "mvendorid_ro");
    csr_insn(32'h60C, CSR_MSTATUS, 32'hFFFF_FF77);
    exp_flush(32'h610, 1'b0);
    fire();
    rd(CSR_MSTATUS, 32'h0000_1800, "mstatus_masked");

    // pc+4 wraps
    csr_insn(32'hFFFF_FFFC, CSR_MSCRATCH, 32'h1);
    exp_flush(32'h0, 1'b0);
    fire();

    // Asynchronous reset in the middle of a flush
    csr_insn(32'h700, CSR_MTVEC, 32'h4000_0000);
    exu.in_fencei = 1'b1;
    step();
    idle();
    #1;
    reset = 1'b1;
    exp_sig(SEL_FLUSH, 32'd0, "reset_drops_flush");
    exp_sig(SEL_FENCE, 32'd0, "reset_drops_fencei");
    step();
    reset = 1'b0;
    rd(CSR_MTVEC,    32'h3000_0000, "mtvec_after_reset");
    rd(CSR_MSCRATCH, 32'h0,         "mscratch_after_reset");

    done = 1'b1;
  end

endmodule
